// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Load/store unit: aligns a request, drives the memory port, extends loads.
// Revision : 1.0
// ============================================================================

module lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_fault,
  output logic              resp_timeout,
  output logic [XLEN-1:0]   mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [XLEN/8-1:0] mem_byte_enable,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_resp
);

  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int LB = $clog2(XLEN);
  localparam bit          c_IS64    = (XLEN == 64);
  localparam logic [31:0] c_TIMEOUT = 32'(TIMEOUT);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ACCESS = 2'd1;
  localparam logic [1:0] c_DONE   = 2'd2;
  localparam logic [1:0] c_FAULT  = 2'd3;

  logic [1:0]      r_state;
  logic            r_we;
  logic [2:0]      r_funct3;
  logic [OB-1:0]   r_off;
  logic [XLEN-1:0] r_addr;
  logic [NB-1:0]   r_be;
  logic [XLEN-1:0] r_wdata;
  logic [31:0]     r_cnt;
  logic [XLEN-1:0] r_rdata;
  logic            r_timeout;

  logic [OB-1:0]   w_off;
  logic [2:0]      w_align;
  logic            w_misaligned;
  logic            w_legal;
  logic [NB-1:0]   w_lanes;
  logic [XLEN-1:0] w_shifted;
  logic [LB-1:0]   w_msb;
  logic            w_sign;
  logic [XLEN-1:0] w_load;
  logic            w_timeout_hit;
  logic            w_access;

  assign w_off = req_addr[OB-1:0];

  always_comb begin
    w_align = 3'b000;
    w_lanes = NB'(1);
    case (req_funct3[1:0])
      2'd0:    begin w_align = 3'b000; w_lanes = NB'(1);   end
      2'd1:    begin w_align = 3'b001; w_lanes = NB'(3);   end
      2'd2:    begin w_align = 3'b011; w_lanes = NB'(15);  end
      default: begin w_align = 3'b111; w_lanes = NB'(255); end
    endcase
  end

  assign w_misaligned = |(req_addr[2:0] & w_align);

  always_comb begin
    w_legal = 1'b1;
    if (req_we) begin
      w_legal = !req_funct3[2] && ((req_funct3[1:0] != 2'b11) || c_IS64);
    end else begin
      case (req_funct3)
        3'b011, 3'b110: w_legal = c_IS64;
        3'b111:         w_legal = 1'b0;
        default:        w_legal = 1'b1;
      endcase
    end
  end

  // Load path: bring the addressed lane down to bit 0, then extend above the access MSB.
  assign w_shifted = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_msb = LB'(7);
    case (r_funct3[1:0])
      2'd0:    w_msb = LB'(7);
      2'd1:    w_msb = LB'(15);
      2'd2:    w_msb = LB'(31);
      default: w_msb = LB'(63);
    endcase
  end

  assign w_sign = ~r_funct3[2] & w_shifted[w_msb];

  always_comb begin
    w_load = '0;
    for (int i = 0; i < XLEN; i++) begin
      w_load[i] = (LB'(i) <= w_msb) ? w_shifted[i] : w_sign;
    end
  end

  assign w_timeout_hit = (c_TIMEOUT != 32'd0) && ((r_cnt + 32'd1) == c_TIMEOUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_IDLE;
      r_we      <= 1'b0;
      r_funct3  <= 3'b000;
      r_off     <= '0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_cnt     <= 32'd0;
      r_rdata   <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (req_valid) begin
            r_we      <= req_we;
            r_funct3  <= req_funct3;
            r_off     <= w_off;
            r_addr    <= req_addr & ~XLEN'(NB - 1);
            r_be      <= w_lanes << w_off;
            r_wdata   <= req_wdata << {w_off, 3'b000};
            r_cnt     <= 32'd0;
            r_timeout <= 1'b0;
            if (!w_legal || w_misaligned) begin
              r_rdata <= '0;
              r_state <= c_FAULT;
            end else begin
              r_state <= c_ACCESS;
            end
          end
        end
        c_ACCESS: begin
          r_cnt <= r_cnt + 32'd1;
          // A response arriving on the timeout cycle still wins.
          if (mem_resp) begin
            r_rdata <= r_we ? '0 : w_load;
            r_state <= c_DONE;
          end else if (w_timeout_hit) begin
            r_rdata   <= '0;
            r_timeout <= 1'b1;
            r_state   <= c_DONE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign w_access        = (r_state == c_ACCESS);
  assign req_ready       = (r_state == c_IDLE);
  assign resp_valid      = (r_state == c_DONE) || (r_state == c_FAULT);
  assign resp_fault      = (r_state == c_FAULT);
  assign resp_timeout    = (r_state == c_DONE) && r_timeout;
  assign resp_rdata      = r_rdata;
  assign mem_read        = w_access && !r_we;
  assign mem_write       = w_access && r_we;
  assign mem_address     = w_access ? r_addr  : '0;
  assign mem_byte_enable = w_access ? r_be    : '0;
  assign mem_wdata       = w_access ? r_wdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Randomised bench for lsu (XLEN=32 untimed and XLEN=64 with TIMEOUT=4).
// Revision : 1.0
// ============================================================================

module tb_lsu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sel64, req_valid, req_we, mem_resp;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata, mem_rdata;

  logic        a_ready, a_rv, a_fault, a_to, a_rd, a_wr;
  logic [31:0] a_rdata, a_addr, a_wd;
  logic [3:0]  a_be;
  logic        b_ready, b_rv, b_fault, b_to, b_rd, b_wr;
  logic [63:0] b_rdata, b_addr, b_wd;
  logic [7:0]  b_be;

  lsu #(.XLEN(32), .TIMEOUT(0)) u_lsu32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & ~sel64), .req_ready(a_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
    .resp_valid(a_rv), .resp_rdata(a_rdata), .resp_fault(a_fault), .resp_timeout(a_to),
    .mem_address(a_addr), .mem_read(a_rd), .mem_write(a_wr), .mem_byte_enable(a_be),
    .mem_wdata(a_wd), .mem_rdata(mem_rdata[31:0]), .mem_resp(mem_resp)
  );

  lsu #(.XLEN(64), .TIMEOUT(4)) u_lsu64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & sel64), .req_ready(b_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(b_rv), .resp_rdata(b_rdata), .resp_fault(b_fault), .resp_timeout(b_to),
    .mem_address(b_addr), .mem_read(b_rd), .mem_write(b_wr), .mem_byte_enable(b_be),
    .mem_wdata(b_wd), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  // View of whichever unit is currently being exercised.
  logic        v_ready, v_rv, v_fault, v_to, v_rd, v_wr, o_busy;
  logic [63:0] v_rdata, v_addr, v_wd, v_be;

  always_comb begin
    if (sel64) begin
      v_ready = b_ready; v_rv = b_rv; v_fault = b_fault; v_to = b_to;
      v_rd = b_rd; v_wr = b_wr; v_rdata = b_rdata; v_addr = b_addr;
      v_wd = b_wd; v_be = {56'b0, b_be};
      o_busy = a_rv | a_rd | a_wr | ~a_ready;
    end else begin
      v_ready = a_ready; v_rv = a_rv; v_fault = a_fault; v_to = a_to;
      v_rd = a_rd; v_wr = a_wr; v_rdata = {32'b0, a_rdata}; v_addr = {32'b0, a_addr};
      v_wd = {32'b0, a_wd}; v_be = {60'b0, a_be};
      o_busy = b_rv | b_rd | b_wr | ~b_ready;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  // Reference model: whole-transaction result computed from address arithmetic.
  task automatic model(input bit is64, input bit we, input logic [2:0] f3,
                       input logic [63:0] addr_in, input logic [63:0] wdata_in,
                       input logic [63:0] mrd_in, output bit fault,
                       output logic [63:0] maddr, output logic [63:0] be,
                       output logic [63:0] wd, output logic [63:0] rd);
    logic [63:0] xm, addr, wdata, mrd, szmask, raw;
    int size, nb, off;
    bit legal;
    xm    = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    addr  = addr_in & xm;
    wdata = wdata_in & xm;
    mrd   = mrd_in & xm;
    nb    = is64 ? 8 : 4;
    size  = 1 << f3[1:0];
    if (we) legal = (f3 inside {3'd0, 3'd1, 3'd2}) || (is64 && f3 == 3'd3);
    else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (is64 && (f3 inside {3'd3, 3'd6}));
    fault  = !legal || ((addr % size) != 0);
    off    = int'(addr % nb);
    maddr  = addr - off;
    be     = ((64'd1 << size) - 1) << off;
    wd     = (wdata << (8 * off)) & xm;
    szmask = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 1);
    raw    = (mrd >> (8 * off)) & szmask;
    if (!f3[2] && raw[8*size-1]) raw = raw | ~szmask;
    rd = (we || fault) ? 64'd0 : (raw & xm);
  endtask

  localparam logic [1:0] P_IDLE = 2'd0, P_ACC = 2'd1, P_RESP = 2'd2, P_SKIP = 2'd3;
  logic [1:0]  phase;
  bit          e_we, e_fault, e_to;
  logic [63:0] e_addr, e_be, e_wd, e_rd;

  always @(negedge clk) begin
    if (!rst && phase != P_SKIP) begin
      chk("other_unit_idle", o_busy, 0);
      case (phase)
        P_IDLE: begin
          chk("idle_ready", v_ready, 1);
          chk("idle_outputs", {v_rv, v_rd, v_wr}, 0);
        end
        P_ACC: begin
          chk("acc_ready", v_ready, 0);
          chk("acc_resp_valid", v_rv, 0);
          chk("acc_read", v_rd, !e_we);
          chk("acc_write", v_wr, e_we);
          chk("acc_address", v_addr, e_addr);
          chk("acc_be", v_be, e_be);
          if (e_we) chk("acc_wdata", v_wd, e_wd);
        end
        P_RESP: begin
          chk("resp_valid", v_rv, 1);
          chk("resp_ready", v_ready, 0);
          chk("resp_strobes", {v_rd, v_wr}, 0);
          chk("resp_fault", v_fault, e_fault);
          chk("resp_timeout", v_to, e_to);
          if (!e_to) chk("resp_rdata", v_rdata, e_rd);
        end
        default: ;
      endcase
    end
  end

  // lat = ACCESS cycle carrying mem_resp (1 = earliest); 0 = never respond.
  task automatic txn(input bit is64, input bit we, input logic [2:0] f3,
                     input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [63:0] mrd, input int lat);
    int n;
    bit done;
    sel64 = is64; req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; mem_rdata = mrd;
    mem_resp = 1'($urandom_range(0, 1));
    model(is64, we, f3, addr, wdata, mrd, e_fault, e_addr, e_be, e_wd, e_rd);
    e_we = we; e_to = 1'b0;
    @(posedge clk); #2;
    req_valid = 1'b0; mem_resp = 1'b0;
    if (!e_fault) begin
      phase = P_ACC; n = 0; done = 1'b0;
      while (!done) begin
        n++;
        mem_resp  = (n == lat);
        req_valid = 1'($urandom_range(0, 1));
        @(posedge clk); #2;
        req_valid = 1'b0;
        if (mem_resp) done = 1'b1;
        else if (is64 && n == 4) begin done = 1'b1; e_to = 1'b1; end
        else if (n >= 40) begin
          total++; bad++; done = 1'b1;
          $display("FAIL access_bound: got=%0d cycles want<40", n);
        end
        mem_resp = 1'b0;
      end
    end
    phase = P_RESP;
    mem_resp  = 1'($urandom_range(0, 1));
    req_valid = 1'($urandom_range(0, 1));
    @(posedge clk); #2;
    phase = P_IDLE; mem_resp = 1'b0; req_valid = 1'b0;
  endtask

  bit          p_f;
  logic [63:0] p_a, p_be, p_wd, p_rd;

  initial begin
    phase = P_SKIP; rst = 1'b1; sel64 = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'b000; req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    e_we = 1'b0; e_fault = 1'b0; e_to = 1'b0; e_addr = '0; e_be = '0; e_wd = '0; e_rd = '0;
    #2;
    chk("rst_ready32", a_ready, 1);
    chk("rst_ctrl32", {a_rv, a_fault, a_to, a_rd, a_wr, a_be}, 0);
    chk("rst_data32", a_rdata | a_addr | a_wd, 0);
    chk("rst_ready64", b_ready, 1);
    chk("rst_ctrl64", {b_rv, b_fault, b_to, b_rd, b_wr, b_be}, 0);
    chk("rst_data64", b_rdata | b_addr | b_wd, 0);

    model(0, 0, 3'b000, 64'h1003, 0, 64'h80FF_1234, p_f, p_a, p_be, p_wd, p_rd);
    chk("pin_lb_addr", p_a, 64'h1000);
    chk("pin_lb_be", p_be, 64'h8);
    chk("pin_lb_rdata", p_rd, 64'hFFFF_FF80);
    model(0, 0, 3'b101, 64'h2002, 0, 64'hBEEF_0000, p_f, p_a, p_be, p_wd, p_rd);
    chk("pin_lhu_be", p_be, 64'hC);
    chk("pin_lhu_rdata", p_rd, 64'h0000_BEEF);
    model(0, 0, 3'b001, 64'h2002, 0, 64'hBEEF_0000, p_f, p_a, p_be, p_wd, p_rd);
    chk("pin_lh_rdata", p_rd, 64'hFFFF_BEEF);
    model(0, 1, 3'b000, 64'h3001, 64'hAABB_CCDD, 0, p_f, p_a, p_be, p_wd, p_rd);
    chk("pin_sb_be", p_be, 64'h2);
    chk("pin_sb_wdata", p_wd[15:8], 64'hDD);
    model(0, 0, 3'b010, 64'h4002, 0, 0, p_f, p_a, p_be, p_wd, p_rd);
    chk("pin_lw_misaligned", p_f, 1);
    model(1, 0, 3'b011, 64'h8, 0, 64'h0123_4567_89AB_CDEF, p_f, p_a, p_be, p_wd, p_rd);
    chk("pin_ld_be", p_be, 64'hFF);
    chk("pin_ld_rdata", p_rd, 64'h0123_4567_89AB_CDEF);
    model(1, 0, 3'b110, 64'hC, 0, 64'h0123_4567_89AB_CDEF, p_f, p_a, p_be, p_wd, p_rd);
    chk("pin_lwu_rdata", p_rd, 64'h0000_0000_0123_4567);

    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0; phase = P_IDLE;

    txn(0, 0, 3'b000, 64'h1003, 0, 64'h80FF_1234, 1);
    txn(0, 0, 3'b101, 64'h2002, 0, 64'hBEEF_0000, 1);
    txn(0, 0, 3'b001, 64'h2002, 0, 64'hBEEF_0000, 2);
    txn(0, 1, 3'b000, 64'h3001, 64'hAABB_CCDD, 0, 6);
    txn(0, 0, 3'b010, 64'h4002, 0, 0, 1);
    txn(0, 1, 3'b100, 64'h4000, 64'h1234, 0, 1);
    txn(1, 0, 3'b010, 64'h100, 0, 64'h55, 0);
    txn(1, 0, 3'b010, 64'h104, 0, 64'h8765_4321_0000_0000, 4);
    txn(1, 0, 3'b011, 64'h8, 0, 64'h0123_4567_89AB_CDEF, 1);
    txn(1, 0, 3'b110, 64'hC, 0, 64'h0123_4567_89AB_CDEF, 1);

    // Reset in the middle of an access must drop strobes without a response.
    sel64 = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 64'h100; mem_resp = 1'b0;
    model(1, 0, 3'b010, 64'h100, 0, 0, e_fault, e_addr, e_be, e_wd, e_rd);
    e_we = 1'b0; e_to = 1'b0;
    @(posedge clk); #2;
    req_valid = 1'b0; phase = P_ACC;
    repeat (2) begin @(posedge clk); #2; end
    phase = P_SKIP; rst = 1'b1; #1;
    chk("rst_mid_read", b_rd, 0);
    chk("rst_mid_ready", b_ready, 1);
    chk("rst_mid_resp_valid", b_rv, 0);
    chk("rst_mid_addr", b_addr, 0);
    @(posedge clk); #2;
    chk("rst_hold_resp_valid", b_rv, 0);
    rst = 1'b0; phase = P_IDLE;

    for (int i = 0; i < 300; i++) begin
      bit          r64, rwe;
      logic [2:0]  rf3;
      logic [63:0] raddr;
      int          gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #2; end
      r64   = 1'($urandom_range(0, 1));
      rwe   = 1'($urandom_range(0, 1));
      rf3   = 3'($urandom_range(0, 7));
      raddr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) raddr = raddr & ~((64'd1 << rf3[1:0]) - 64'd1);
      txn(r64, rwe, rf3, raddr, {$urandom, $urandom}, {$urandom, $urandom},
          r64 ? $urandom_range(0, 6) : $urandom_range(1, 6));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
